// File: rtl/octal_display_scanner.sv
// octal_display_scanner
//   Feeds the shared 7-segment decoder. An 8-bit value is latched from the
//   datapath, split into three octal digits and scanned one digit at a time
//   onto a single 4-bit digit code, with active-low anode enables per digit.
//   A newly loaded value only reaches the display at a frame boundary, so one
//   frame never mixes digits of an old and a new value.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       single-cycle strobe, captures value
//   value      binary value to display
//   count      digit code to the segment decoder (always 0..7)
//   anode      digit enables, active low, bit i = octal digit i
//   digit_idx  digit currently being scanned (0..2)
//   pending    a loaded value is waiting for the frame boundary
//
// Digit scan register
//   digit_idx | meaning
//   0         | low octal digit, disp_reg[2:0], never blanked
//   1         | middle octal digit, disp_reg[5:3]
//   2         | top octal digit, disp_reg[7:6]; its tick is the frame boundary
//   3         | unreachable, recovers to 0 on the next tick
module octal_display_scanner #(
  parameter int PRESCALE      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic [3:0] count,
  output logic [2:0] anode,
  output logic [1:0] digit_idx,
  output logic       pending
);

  localparam int              PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic          frame_end;
  logic [7:0]    disp_reg;
  logic [7:0]    pend_reg;
  logic [2:0]    digit;

  assign tick      = (prescaler == PS_LAST);
  assign frame_end = tick && (digit_idx == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= 2'd0;
    end else if (tick) begin
      case (digit_idx)
        2'd0:    digit_idx <= 2'd1;
        2'd1:    digit_idx <= 2'd2;
        default: digit_idx <= 2'd0;
      endcase
    end
  end

  // A strobe landing exactly on the frame boundary goes straight to the
  // display and supersedes anything older still parked in pend_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg <= 8'd0;
      pend_reg <= 8'd0;
      pending  <= 1'b0;
    end else if (load) begin
      pend_reg <= value;
      if (frame_end) begin
        disp_reg <= value;
        pending  <= 1'b0;
      end else begin
        pending  <= 1'b1;
      end
    end else if (frame_end && pending) begin
      disp_reg <= pend_reg;
      pending  <= 1'b0;
    end
  end

  // Pure decode of registered state, so count and anode switch together
  // with digit_idx and carry no glitches from the load path.
  always_comb begin
    digit = 3'd0;
    anode = 3'b111;
    case (digit_idx)
      2'd0: begin
        digit = disp_reg[2:0];
        anode = 3'b110;
      end
      2'd1: begin
        digit = disp_reg[5:3];
        anode = (BLANK_LEADING && (disp_reg[7:3] == 5'd0)) ? 3'b111 : 3'b101;
      end
      2'd2: begin
        digit = {1'b0, disp_reg[7:6]};
        anode = (BLANK_LEADING && (disp_reg[7:6] == 2'd0)) ? 3'b111 : 3'b011;
      end
      default: begin
        digit = 3'd0;
        anode = 3'b111;
      end
    endcase
  end

  // Bit 3 is tied low so the decoder never falls into its default pattern.
  assign count = {1'b0, digit};

endmodule

// File: tb/tb_octal_display_scanner.sv
module tb_octal_display_scanner;

  localparam int PS = 4;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] value;

  logic [3:0] count_b,  count_n;
  logic [2:0] anode_b,  anode_n;
  logic [1:0] idx_b,    idx_n;
  logic       pend_b,   pend_n;

  octal_display_scanner #(.PRESCALE(PS), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .count(count_b), .anode(anode_b), .digit_idx(idx_b), .pending(pend_b)
  );

  octal_display_scanner #(.PRESCALE(PS), .BLANK_LEADING(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .count(count_n), .anode(anode_n), .digit_idx(idx_n), .pending(pend_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == k after the k-th rising edge since reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         slot;
    int         idx;
    int         cnt;
    logic [2:0] ab;
    logic [2:0] an;
    bit         pend;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input int s, input int idx, input int cnt,
                      input logic [2:0] ab, input logic [2:0] an, input bit p);
    exp_t e;
    e.slot = s; e.idx = idx; e.cnt = cnt; e.ab = ab; e.an = an; e.pend = p;
    sb_q.push_back(e);
  endtask

  // Monitor: at the first sampled cycle of each digit slot, compare against
  // the scoreboard entry for that slot.
  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0 && (cyc % PS) == 0) begin
      int   slot;
      exp_t e;
      slot = cyc / PS;
      while (sb_q.size() > 0 && sb_q[0].slot < slot) begin
        e = sb_q.pop_front();
        chk($sformatf("slot%0d_missed", e.slot), slot, e.slot);
      end
      if (sb_q.size() > 0 && sb_q[0].slot == slot) begin
        e = sb_q.pop_front();
        chk($sformatf("slot%0d_idx", slot),     int'(idx_b),   e.idx);
        chk($sformatf("slot%0d_count", slot),   int'(count_b), e.cnt);
        chk($sformatf("slot%0d_anode", slot),   int'(anode_b), int'(e.ab));
        chk($sformatf("slot%0d_pending", slot), int'(pend_b),  int'(e.pend));
        chk($sformatf("slot%0d_idx_nb", slot),  int'(idx_n),   e.idx);
        chk($sformatf("slot%0d_count_nb", slot),int'(count_n), e.cnt);
        chk($sformatf("slot%0d_anode_nb", slot),int'(anode_n), int'(e.an));
      end
    end
  end

  // Strobe load for one cycle so it is captured on rising edge k.
  task automatic do_load(input logic [7:0] v, input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != k - 1 && guard < 1000);
    if (guard >= 1000) chk($sformatf("load_sync_k%0d", k), cyc, k - 1);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    load  = 1'b0;
    value = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",   int'(count_b), 0);
    chk("rst_anode",   int'(anode_b), 3'b110);
    chk("rst_idx",     int'(idx_b),   0);
    chk("rst_pending", int'(pend_b),  0);

    // Run into the middle of a scan with a value pending, then reset.
    @(negedge clk);
    rst_n = 1'b1;
    do_load(8'hFF, 3);
    while (cyc != 9) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count",    int'(count_b), 0);
    chk("arst_anode",    int'(anode_b), 3'b110);
    chk("arst_idx",      int'(idx_b),   0);
    chk("arst_pending",  int'(pend_b),  0);
    chk("arst_anode_nb", int'(anode_n), 3'b110);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //   slot idx cnt blank   no-blank pending
    push( 0, 0, 0, 3'b110, 3'b110, 1'b0);
    push( 1, 1, 0, 3'b111, 3'b101, 1'b1);
    push( 2, 2, 0, 3'b111, 3'b011, 1'b1);
    push( 3, 0, 7, 3'b110, 3'b110, 1'b0);  // 8'hFF = 377
    push( 4, 1, 7, 3'b101, 3'b101, 1'b1);
    push( 5, 2, 3, 3'b011, 3'b011, 1'b1);
    push( 6, 0, 5, 3'b110, 3'b110, 1'b0);  // 8'h05 = 005
    push( 7, 1, 0, 3'b111, 3'b101, 1'b1);
    push( 8, 2, 0, 3'b111, 3'b011, 1'b1);
    push( 9, 0, 0, 3'b110, 3'b110, 1'b0);  // 8'h08 = 010
    push(10, 1, 1, 3'b101, 3'b101, 1'b1);
    push(11, 2, 0, 3'b111, 3'b011, 1'b1);
    push(12, 0, 0, 3'b110, 3'b110, 1'b0);  // 8'h00, C9 arrives in digit 1
    push(13, 1, 0, 3'b111, 3'b101, 1'b0);
    push(14, 2, 0, 3'b111, 3'b011, 1'b1);
    push(15, 0, 1, 3'b110, 3'b110, 1'b0);  // 8'hC9 = 311
    push(16, 1, 1, 3'b101, 3'b101, 1'b1);
    push(17, 2, 3, 3'b011, 3'b011, 1'b1);
    push(18, 0, 2, 3'b110, 3'b110, 1'b0);  // 8'h22 = 042 wins over 8'h11
    push(19, 1, 4, 3'b101, 3'b101, 1'b0);
    push(20, 2, 0, 3'b111, 3'b011, 1'b0);

    do_load(8'hFF, 1);
    do_load(8'h05, 13);
    do_load(8'h08, 25);
    do_load(8'h00, 37);
    do_load(8'hC9, 53);
    do_load(8'h11, 62);
    do_load(8'h22, 72);

    guard = 0;
    while (sb_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) chk("scoreboard_drain", sb_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/octal_display_scanner.md
Name: octal_display_scanner

Overview:
- Upstream feeder for the 7-segment decoder.
- Latches an 8-bit value from the datapath, for example the accumulator or output port. Splits it into three octal digits (0–7, the range the decoder renders) and time-multiplexes them onto one shared 4-bit digit code, with per-digit active-low anode enables.
- Updates to the displayed value are deferred to a frame boundary so a frame never shows mixed old/new digits.

Parameters:
- PRESCALE, 50000, clk cycles each digit is held (≥2). Simulation uses 4.
- BLANK_LEADING, 1, when 1, leading zero digits above digit 0 are blanked through their anode.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures value.
- value  input  8  binary value to display.
- count  output  4  digit code to the segment decoder, always 0–7.
- anode  output  3  digit enables, active low; bit i = octal digit i.
- digit_idx  output  2  currently scanned digit, 0–2.
- pending  output  1  a loaded value is waiting for the frame boundary.

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit_idx=0, disp_reg=0, pend_reg=0, pending=0.
  - Hence count=4'd0, anode=3'b110.
- Prescaler:
  - Counts 0..PRESCALE-1; tick asserts when it equals PRESCALE-1, then it wraps to 0.
- Digit register:
  - On tick, digit_idx advances 0→1→2→0. Value 3 is unreachable; if ever seen, the next tick forces it to 0.
  - Each digit is held exactly PRESCALE cycles; a frame is 3*PRESCALE cycles.
- Frame boundary: tick while digit_idx==2.
- Digit extraction from disp_reg:
  - d0=disp_reg[2:0]
  - d1=disp_reg[5:3]
  - d2={1'b0,disp_reg[7:6]}
  - count={1'b0,d[digit_idx]}. Bit 3 is always 0, so the decoder never reaches its default pattern.
- Anode:
  - One-hot low at digit_idx, i.e. 110/101/011 for digits 0/1/2.
  - If BLANK_LEADING: anode=111 while digit_idx==2 and disp_reg[7:6]==0, and while digit_idx==1 and disp_reg[7:3]==0.
  - Digit 0 is never blanked.
  - count is still driven during blanked slots.
- count and anode are decoded only from registers (digit_idx, disp_reg), so they are glitch-free and change in the same cycle digit_idx changes.
- Load handshake:
  - load=1 → pend_reg<=value and pending<=1 on that edge.
  - Multiple loads before the boundary: the last one wins.
- At a frame boundary with pending=1 (and no load that cycle): disp_reg<=pend_reg and pending<=0. The new value appears at digit 0 of the next frame.
- At a frame boundary with load=1 in the same cycle: disp_reg<=value directly and pending<=0. The strobed value takes priority over any older pend_reg.
- At a frame boundary with pending=0 and load=0: disp_reg is held.
- Load never alters the prescaler or digit_idx.
- Reset mid-frame: all state clears immediately, and any pending value is discarded.

Test Plan:
- Reset/idle, PRESCALE=4: assert rst_n=0 mid-scan → anode=110, count=0, digit_idx=0 asynchronously. After release, digit_idx steps 0,1,2,0 every 4 cycles, and anode shows 110, then 111, then 111, because disp_reg is 0 and both upper digits are blanked.
- Full value: load 8'hFF (octal 377) at cycle 1 → pending=1 until the boundary at cycle 12. Next frame shows count 7/7/3 with anode 110/101/011, and pending=0.
- Leading blank: load 8'h05 → next frame: digit0 count=5 anode=110; digit1 and digit2 anode=111. Then load 8'h08 (octal 010) → digit1 count=1 anode=101, digit2 blanked.
- No tearing: with 8'h00 displayed, load 8'hC9 (octal 311) during digit 1 → remainder of the frame still shows 0 digits. Next frame shows 1/1/3 exactly.
- Priority: load 8'h11 mid-frame, then 8'h22 in the boundary cycle → next frame shows 8'h22 (2/4/0, digit2 blanked), and pending=0.
- BLANK_LEADING=0, value 8'h05 → anodes cycle 110/101/011 and count cycles 5/0/0.
